buffer_rr_scheduler: RTL and testbench
======================================

Name: buffer_rr_scheduler

Overview:
- Round-robin read scheduler that drains N_QUEUES show-ahead byte buffers onto one shared output word stream.
- Sits between the per-lane buffers and the downstream consumer.
- Issues one-hot pops, registers the selected head word, honours downstream PAUSE, and enforces a per-queue burst limit.

Parameters:
- N_QUEUES, 4, number of source buffers (>=2).
- DATA_WIDTH, 8, word width.
- BURST_MAX, 2, max consecutive words from one queue while another queue is non-empty (>=1).
- INIT_CYCLES, 3, post-reset settle cycles before arbitration starts (>=1).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- EMPTY  input  N_QUEUES  per-queue empty flag; 1 = empty.
- DATA_IN  input  N_QUEUES*DATA_WIDTH  head word of each queue; queue i is at [i*DATA_WIDTH +: DATA_WIDTH], valid whenever EMPTY[i]=0.
- PAUSE  input  1  downstream backpressure; 1 = no transfer this cycle.
- READ  output  N_QUEUES  one-hot pop, combinational; the queue pops on the edge where READ[i]=1.
- DATA_OUT  output  DATA_WIDTH  registered word.
- VALID  output  1  registered; DATA_OUT is new this cycle.
- STATE  output  2  0=RST, 1=INIT, 2=IDLE, 3=ACTIVE.
- IDLE_OUT  output  1  combinational; 1 when STATE=IDLE.

Behaviour:
- Reset (RESET=0, async), effective immediately:
  - STATE=RST; READ=0 (gated by RESET combinationally); DATA_OUT=0; VALID=0.
  - cur=N_QUEUES-1; burst_cnt=BURST_MAX (exhausted); init_cnt=0.
- RST: first rising edge with RESET=1 -> INIT.
- INIT:
  - init_cnt increments each edge; after INIT_CYCLES edges in INIT -> IDLE.
  - EMPTY and PAUSE are ignored; READ=0.
- Selection (combinational, evaluated only in IDLE/ACTIVE with PAUSE=0):
  - If EMPTY[cur]=0 and burst_cnt<BURST_MAX: sel=cur (continue burst).
  - Otherwise: search cur+1, cur+2, ... wrapping modulo N_QUEUES, ending at cur itself. sel = first queue with EMPTY=0.
  - No non-empty queue: no grant.
  - Only cur non-empty with burst exhausted: cur is re-granted as a new burst.
- Transfer (grant exists and PAUSE=0):
  - READ[sel]=1 this cycle.
  - At the edge: DATA_OUT<=DATA_IN[sel]; VALID<=1; cur<=sel.
  - burst_cnt<=burst_cnt+1 if continuing a burst, else 1.
  - Latency: head word appears on DATA_OUT one edge after READ is sampled high; zero bubble between back-to-back transfers.
- No transfer:
  - READ=0; at the edge VALID<=0.
  - DATA_OUT, cur and burst_cnt hold.
- State transitions:
  - IDLE -> ACTIVE on a transfer edge.
  - ACTIVE -> IDLE on an edge with no transfer and EMPTY all ones.
  - ACTIVE holds while PAUSE=1 with data pending.
  - IDLE holds otherwise.
- PAUSE is combinational into READ: asserting it blocks the pop in the same cycle. Burst position is preserved across pauses.
- Queue going empty mid-burst: the next edge rotates; the burst counter restarts at 1 on the new queue.
- Reset asserted mid-transfer: READ drops immediately; no pop is counted; all state returns to reset values.
- Counter widths: clog2(BURST_MAX+1) for burst_cnt and clog2(INIT_CYCLES+1) for init_cnt. No overflow, since both saturate by construction.
- READ is never multi-hot and never asserted in RST/INIT.

Test Plan:
Defaults apply throughout: N=4, W=8, BURST_MAX=2, INIT_CYCLES=3.
1. Reset/init: hold RESET=0 for 3 cycles, release with EMPTY=4'b0000.
   -> STATE goes RST, INIT (3 edges), then IDLE. READ=0 throughout. First grant is READ=4'b0001 in the IDLE cycle; next edge DATA_OUT = queue0 head, VALID=1, STATE=ACTIVE.
2. Round-robin with burst: all queues hold 4 words, queue i words = 8'hi0..8'hi3; PAUSE=0.
   -> DATA_OUT sequence 00,01,10,11,20,21,30,31,02,03,12,...; VALID continuously 1.
3. Single source: only queue 2 non-empty with AA,BB,CC,DD,EE.
   -> AA..EE emitted on 5 consecutive edges via READ=4'b0100 (re-granted after each burst). When EMPTY becomes 4'b1111, VALID=0 and STATE=IDLE on the next edge.
4. Backpressure: during scenario 2, raise PAUSE for 3 cycles after word 10.
   -> READ=0 and VALID=0 for 3 edges; DATA_OUT holds 8'h10; STATE stays ACTIVE. On release the next word is 8'h11 (burst resumed).
5. Mid-burst empty: queue0={A6}, queue1={39,A8,F9}.
   -> Emitted sequence A6,39,A8,F9; burst counter restarts on queue1.
6. Async reset mid-stream: drop RESET between clock edges while READ=4'b0010.
   -> READ=0, VALID=0, DATA_OUT=0 immediately. After release, INIT is repeated and arbitration restarts at queue0.

Source files
------------

// File: rtl/buffer_rr_scheduler.sv
// Round-robin drain of N show-ahead buffers onto one word stream with a per-queue burst cap.
// One-edge latency from pop to DATA_OUT; PAUSE blocks READ combinationally and freezes burst position.
module buffer_rr_scheduler #(
  parameter int N_QUEUES    = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_MAX   = 2,
  parameter int INIT_CYCLES = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [N_QUEUES-1:0]            EMPTY,
  input  logic [N_QUEUES*DATA_WIDTH-1:0] DATA_IN,
  input  logic                           PAUSE,
  output logic [N_QUEUES-1:0]            READ,
  output logic [DATA_WIDTH-1:0]          DATA_OUT,
  output logic                           VALID,
  output logic [1:0]                     STATE,
  output logic                           IDLE_OUT
);

  localparam int IDXW = $clog2(N_QUEUES);
  localparam int BW   = $clog2(BURST_MAX + 1);
  localparam int IW   = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       cur_q, cur_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [IW-1:0]         init_q, init_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] din [N_QUEUES];
  logic [IDXW-1:0]       sel;
  logic [IDXW-1:0]       cand;
  logic                  grant;
  logic                  cont;
  logic                  arb_en;
  int                    idx;

  for (genvar g = 0; g < N_QUEUES; g++) begin : g_din
    assign din[g] = DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Descending search so the nearest queue after cur is the last (winning) assignment.
  always_comb begin
    sel    = cur_q;
    cand   = cur_q;
    idx    = 0;
    grant  = 1'b0;
    cont   = 1'b0;
    arb_en = RESET && !PAUSE && (state_q == ST_IDLE || state_q == ST_ACTIVE);
    if (!EMPTY[cur_q] && (burst_q < BW'(BURST_MAX))) begin
      sel   = cur_q;
      grant = 1'b1;
      cont  = 1'b1;
    end else begin
      for (int k = N_QUEUES; k >= 1; k--) begin
        idx  = (int'(cur_q) + k) % N_QUEUES;
        cand = IDXW'(idx);
        if (!EMPTY[cand]) begin
          sel   = cand;
          grant = 1'b1;
        end
      end
    end
    grant = grant && arb_en;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    burst_d = burst_q;
    init_d  = init_q;
    data_d  = data_q;
    valid_d = 1'b0;
    READ    = '0;
    case (state_q)
      ST_RST: state_d = ST_INIT;
      ST_INIT: begin
        init_d = init_q + IW'(1);
        if (init_q == IW'(INIT_CYCLES - 1)) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (grant) begin
          READ[sel] = 1'b1;
          data_d    = din[sel];
          valid_d   = 1'b1;
          cur_d     = sel;
          burst_d   = cont ? burst_q + BW'(1) : BW'(1);
          state_d   = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE && (&EMPTY)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RST;
      cur_q   <= IDXW'(N_QUEUES - 1);
      burst_q <= BW'(BURST_MAX);
      init_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      burst_q <= burst_d;
      init_q  <= init_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign DATA_OUT = data_q;
  assign VALID    = valid_q;
  assign STATE    = state_q;
  assign IDLE_OUT = (state_q == ST_IDLE);

endmodule

// File: tb/tb_buffer_rr_scheduler.sv
// Bench for buffer_rr_scheduler: queue-level reference model feeding a scoreboard, with directed
// scenarios (init, burst round-robin, pause, single source, mid-burst empty, async reset) then random traffic.
module tb_buffer_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BM = 2;
  localparam int IC = 3;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   EMPTY;
  logic [N*W-1:0] DATA_IN;
  logic           PAUSE;
  logic [N-1:0]   READ;
  logic [W-1:0]   DATA_OUT;
  logic           VALID;
  logic [1:0]     STATE;
  logic           IDLE_OUT;

  buffer_rr_scheduler #(.N_QUEUES(N), .DATA_WIDTH(W), .BURST_MAX(BM), .INIT_CYCLES(IC)) dut (
    .CLK(CLK), .RESET(RESET), .EMPTY(EMPTY), .DATA_IN(DATA_IN), .PAUSE(PAUSE),
    .READ(READ), .DATA_OUT(DATA_OUT), .VALID(VALID), .STATE(STATE), .IDLE_OUT(IDLE_OUT)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  logic [W-1:0] src [N][$];
  logic [W-1:0] sb [$];
  logic [W-1:0] got [$];

  int e, m_cur, m_cnt, n_grants, last_g, pause_left, pause_prob;
  bit m_active, prev_xfer, prev_allempty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    e = 0; m_cur = N - 1; m_cnt = BM; m_active = 0;
    prev_xfer = 0; prev_allempty = 0; last_g = -1;
    sb.delete();
  endtask

  function automatic int model_pick();
    if (!(RESET && e > IC && !PAUSE)) return -1;
    if (src[m_cur].size() > 0 && m_cnt < BM) return m_cur;
    for (int k = 1; k <= N; k++)
      if (src[(m_cur + k) % N].size() > 0) return (m_cur + k) % N;
    return -1;
  endfunction

  // One cycle: check registered state at negedge, drive queue heads, predict the grant.
  task automatic step();
    int g, exp_state;
    bit cont, alle;
    @(negedge CLK);
    if (RESET) begin
      if (e < 1000) e++;
      if (prev_xfer) m_active = 1;
      else if (prev_allempty) m_active = 0;
    end
    exp_state = (!RESET || e == 0) ? 0 : (e <= IC) ? 1 : (m_active ? 3 : 2);
    chk("state", STATE, exp_state);
    chk("idle_out", IDLE_OUT, exp_state == 2);
    PAUSE = (pause_left > 0) || (pause_prob > 0 && $urandom_range(99) < pause_prob);
    if (pause_left > 0) pause_left--;
    for (int i = 0; i < N; i++) begin
      EMPTY[i] = (src[i].size() == 0);
      DATA_IN[i*W +: W] = (src[i].size() > 0) ? src[i][0] : W'($urandom);
    end
    #1;
    alle = &EMPTY;
    cont = (src[m_cur].size() > 0 && m_cnt < BM);
    g = model_pick();
    chk("read", READ, (g >= 0) ? (1 << g) : 0);
    if (g >= 0) begin
      sb.push_back(src[g].pop_front());
      n_grants++;
      m_cnt = cont ? m_cnt + 1 : 1;
      m_cur = g;
    end
    last_g = g;
    prev_xfer = (g >= 0);
    prev_allempty = alle;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic chk_seq(input string name, input logic [W-1:0] exp [$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  initial begin : monitor
    logic [W-1:0] last;
    logic [W-1:0] x;
    last = '0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        last = '0;
        chk("rst_valid", VALID, 0);
        chk("rst_dout", DATA_OUT, 0);
      end else if (VALID) begin
        got.push_back(DATA_OUT);
        if (sb.size() == 0) chk("unexpected_valid", VALID, 0);
        else begin
          x = sb.pop_front();
          chk("dout", DATA_OUT, x);
          last = x;
        end
      end else begin
        if (sb.size() > 0) begin
          chk("missing_valid", VALID, 1);
          void'(sb.pop_front());
        end
        chk("dout_hold", DATA_OUT, last);
      end
    end
  end

  initial begin
    logic [W-1:0] exp [$];
    logic [W-1:0] h0;
    int guard;
    RESET = 1'b0; PAUSE = 1'b0; EMPTY = '1; DATA_IN = '0;
    pause_left = 0; pause_prob = 0; n_grants = 0;
    reset_model();

    // Reset/init, burst round-robin, and a 3-cycle pause right after word 10.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) src[i].push_back(W'(i * 16 + j));
    run(3);
    RESET = 1'b1;
    got.delete();
    for (int c = 0; c < 32; c++) begin
      if (n_grants == 3 && c < 12 && pause_left == 0 && PAUSE == 1'b0) pause_left = 3;
      step();
    end
    exp.delete();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++)
        for (int b = 0; b < 2; b++) exp.push_back(W'(q * 16 + r * 2 + b));
    chk_seq("rr_burst", exp);

    // Single source is re-granted after each exhausted burst.
    got.delete();
    src[2] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run(10);
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    chk_seq("single", exp);
    chk("single_idle", STATE, 2);

    // Queue empties mid-burst.
    got.delete();
    src[0] = '{8'hA6};
    src[1] = '{8'h39, 8'hA8, 8'hF9};
    run(8);
    exp = '{8'hA6, 8'h39, 8'hA8, 8'hF9};
    chk_seq("mid_empty", exp);

    // Asynchronous reset between edges while queue 1 is being popped.
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      for (int j = 0; j < 4; j++) src[i].push_back(W'($urandom));
    end
    guard = 0;
    do begin step(); guard++; end while (last_g != 1 && guard < 20);
    chk("rst_pre_read", READ, 4'b0010);
    #1 RESET = 1'b0;
    #1;
    chk("async_read", READ, 0);
    chk("async_valid", VALID, 0);
    chk("async_dout", DATA_OUT, 0);
    src[1].push_front(sb.pop_back());
    n_grants--;
    reset_model();
    run(2);
    RESET = 1'b1;
    h0 = src[0][0];
    got.delete();
    run(30);
    chk("restart_q0", (got.size() > 0) ? got[0] : '0, h0);

    // Random traffic with random pauses, then drain.
    pause_prob = 20;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(1) == 1) begin
        int q;
        q = $urandom_range(N - 1);
        if (src[q].size() < 6) src[q].push_back(W'($urandom));
      end
      step();
    end
    pause_prob = 0;
    run(40);
    chk("drained_sb", sb.size(), 0);
    chk("drained_state", STATE, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
